fpu_wb_queue: RTL

//   Result queue between the FPU conversion/arith stages (int->float, etc.) and the FP

---
 rtl/fpu_wb_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/fpu_wb_queue.sv
// FPU result queue feeding the FP register-file write port (valid/ready, FIFO order).
// Define FPU_WB_BYPASS_EN for a zero-latency path when the queue is empty.
module fpu_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [TAG_W-1:0]  tag_d  [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic push, pop, byp, wr_en, rd_en;

  assign in_ready = (count_q != CW'(DEPTH));
  assign count    = count_q;

`ifdef FPU_WB_BYPASS_EN
  assign byp = (count_q == '0) & in_valid
             & out_ready & ~flush;
  assign out_valid = ~flush
                   & ((count_q != '0) | byp);
  assign out_data = byp ? in_data
                        : data_q[rd_ptr_q];
  assign out_tag  = byp ? in_tag
                        : tag_q[rd_ptr_q];
`else
  assign byp       = 1'b0;
  assign out_valid = (count_q != '0);
  assign out_data  = data_q[rd_ptr_q];
  assign out_tag   = tag_q[rd_ptr_q];
`endif

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  // A bypassed entry goes straight through: no write, no read.
  assign wr_en = push & ~byp;
  assign rd_en = pop & ~byp;

  always_comb begin
    data_d   = data_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        data_d[wr_ptr_q] = in_data;
        tag_d[wr_ptr_q]  = in_tag;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      data_q   <= data_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
